traffic_light_monitor: RTL and testbench

- Observer at the other end of the two-light signal interface. Samples both 3-bit lamp vectors `a` and `b` every clock.
- Decodes them into a junction phase and counts completed cycles.
- Checks encoding, interlock, per-light colour sequence and dwell times. Raises a sticky fault with a first-fault code.
- Sits beside the light controller in the FPGA build, feeding the safety LED/status logic.

---
 rtl/traffic_light_monitor.sv | 242 ++++++++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Passive observer for a two-light junction: decodes both lamp vectors into a
// junction phase, counts completed cycles and latches the first fault seen.

// state | meaning
// UNK   | no trusted colour (after reset or an invalid lamp pattern)
// RED   | previous sample showed red
// GRN   | previous sample showed green
// YEL   | previous sample showed yellow
module tlm_light_checker #(
  parameter int GREEN_MIN = 6,
  parameter int GREEN_MAX = 7,
  parameter int YEL_MIN   = 1,
  parameter int YEL_MAX   = 2,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [2:0] lamp_i,
  output logic       inv_err_o,
  output logic       seq_err_o,
  output logic       tim_err_o
);

  typedef enum logic [1:0] {UNK, RED, GRN, YEL} colour_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] G_MIN   = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] G_LIM   = CNT_W'(GREEN_MAX + 1);
  localparam logic [CNT_W-1:0] Y_MIN   = CNT_W'(YEL_MIN);
  localparam logic [CNT_W-1:0] Y_LIM   = CNT_W'(YEL_MAX + 1);

  colour_e          state_q, state_d, colour;
  logic             lamp_ok, legal_step;
  logic [CNT_W-1:0] dwell_q, dwell_d, dwell_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNK;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
    end
  end

  always_comb begin
    colour  = UNK;
    lamp_ok = 1'b1;
    case (lamp_i)
      3'b001:  colour = RED;
      3'b010:  colour = YEL;
      3'b100:  colour = GRN;
      default: lamp_ok = 1'b0;
    endcase

    legal_step = (state_q == RED && colour == GRN) ||
                 (state_q == GRN && colour == YEL) ||
                 (state_q == YEL && colour == RED);
    dwell_inc  = (dwell_q == CNT_SAT) ? dwell_q : dwell_q + CNT_ONE;

    state_d   = state_q;
    dwell_d   = dwell_q;
    inv_err_o = 1'b0;
    seq_err_o = 1'b0;
    tim_err_o = 1'b0;

    if (en_i) begin
      if (!lamp_ok) begin
        inv_err_o = 1'b1;
        state_d   = UNK;
        dwell_d   = '0;
      end else if (state_q == UNK) begin
        state_d = colour;
        dwell_d = CNT_ONE;
      end else if (colour == state_q) begin
        dwell_d   = dwell_inc;
        // watchdog: the limit is hit exactly once per dwell
        tim_err_o = (dwell_inc != dwell_q) &&
                    ((state_q == GRN && dwell_inc == G_LIM) ||
                     (state_q == YEL && dwell_inc == Y_LIM));
      end else begin
        state_d   = colour;
        dwell_d   = CNT_ONE;
        seq_err_o = !legal_step;
        // over-long dwells were already reported by the watchdog
        tim_err_o = (state_q == GRN && dwell_q < G_MIN) ||
                    (state_q == YEL && dwell_q < Y_MIN);
      end
    end
  end

endmodule

module traffic_light_monitor #(
  parameter int GREEN_MIN = 6,
  parameter int GREEN_MAX = 7,
  parameter int YEL_MIN   = 1,
  parameter int YEL_MAX   = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       a,
  input  logic [2:0]       b,
  input  logic             clear,
  output logic [2:0]       phase,
  output logic             phase_valid,
  output logic [CNT_W-1:0] cycle_count,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic             err_pulse
);

  typedef enum logic [1:0] {LAST_NONE, LAST_A, LAST_B} last_e;

  logic [2:0]       a_q, b_q;
  logic             smp_vld_q;
  last_e            last_q, last_d;
  logic [2:0]       phase_q, phase_d;
  logic             phase_valid_q, phase_valid_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic             fault_q, fault_d;
  logic [2:0]       code_q, code_d;
  logic             err_q, err_d;

  logic inv_a, seq_a, tim_a, inv_b, seq_b, tim_b;
  logic a_red, a_grn, a_yel, b_red, b_grn, b_yel, a_act, b_act;
  logic conflict, wrap;
  logic [7:1] err_vec;
  logic [2:0] first_code;

  // smp_vld_q keeps the reset value of the sample registers from being judged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= 3'b000;
      b_q       <= 3'b000;
      smp_vld_q <= 1'b0;
    end else begin
      a_q       <= a;
      b_q       <= b;
      smp_vld_q <= 1'b1;
    end
  end

  tlm_light_checker #(
    .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX),
    .YEL_MIN(YEL_MIN), .YEL_MAX(YEL_MAX), .CNT_W(CNT_W)
  ) u_light_a (
    .clk(clk), .rst_n(rst_n), .en_i(smp_vld_q), .lamp_i(a_q),
    .inv_err_o(inv_a), .seq_err_o(seq_a), .tim_err_o(tim_a)
  );

  tlm_light_checker #(
    .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX),
    .YEL_MIN(YEL_MIN), .YEL_MAX(YEL_MAX), .CNT_W(CNT_W)
  ) u_light_b (
    .clk(clk), .rst_n(rst_n), .en_i(smp_vld_q), .lamp_i(b_q),
    .inv_err_o(inv_b), .seq_err_o(seq_b), .tim_err_o(tim_b)
  );

  always_comb begin
    a_red = (a_q == 3'b001);
    a_yel = (a_q == 3'b010);
    a_grn = (a_q == 3'b100);
    b_red = (b_q == 3'b001);
    b_yel = (b_q == 3'b010);
    b_grn = (b_q == 3'b100);
    a_act = a_grn | a_yel;
    b_act = b_grn | b_yel;
    // an invalid pattern is never "active", so it masks the interlock check
    conflict = smp_vld_q & a_act & b_act;

    phase_d       = phase_q;
    phase_valid_d = phase_valid_q;
    last_d        = last_q;
    wrap          = 1'b0;
    if (smp_vld_q) begin
      phase_valid_d = 1'b1;
      if (a_grn && b_red)                           phase_d = 3'd0;
      else if (a_yel && b_red)                      phase_d = 3'd1;
      else if (a_red && b_grn)                      phase_d = 3'd3;
      else if (a_red && b_yel)                      phase_d = 3'd4;
      else if (a_red && b_red && last_q == LAST_A)  phase_d = 3'd2;
      else if (a_red && b_red && last_q == LAST_B)  phase_d = 3'd5;
      else                                          phase_valid_d = 1'b0;

      if (a_act && b_red) last_d = LAST_A;
      if (b_act && a_red) last_d = LAST_B;

      wrap = phase_valid_q && phase_q == 3'd5 && phase_valid_d && phase_d == 3'd0;
    end

    err_vec    = {tim_b, tim_a, seq_b, seq_a, inv_b, inv_a, conflict};
    first_code = 3'd0;
    for (int i = 7; i >= 1; i--) begin
      if (err_vec[i]) first_code = 3'(i);
    end
    err_d = |err_vec;

    fault_d = fault_q;
    code_d  = code_q;
    cycle_d = wrap ? cycle_q + CNT_W'(1) : cycle_q;
    if (clear) begin
      fault_d = 1'b0;
      code_d  = 3'd0;
      cycle_d = '0;
    end else if (err_d && !fault_q) begin
      fault_d = 1'b1;
      code_d  = first_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q        <= LAST_NONE;
      phase_q       <= 3'd0;
      phase_valid_q <= 1'b0;
      cycle_q       <= '0;
      fault_q       <= 1'b0;
      code_q        <= 3'd0;
      err_q         <= 1'b0;
    end else begin
      last_q        <= last_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
      cycle_q       <= cycle_d;
      fault_q       <= fault_d;
      code_q        <= code_d;
      err_q         <= err_d;
    end
  end

  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign cycle_count = cycle_q;
  assign fault       = fault_q;
  assign fault_code  = code_q;
  assign err_pulse   = err_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios plus randomized controller
// traffic, all checked against a rule-level junction model.
module tb_traffic_light_monitor;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [2:0] R = 3'b001, Y = 3'b010, G = 3'b100;
  localparam logic [2:0] LA [6] = '{G, Y, R, R, R, R};
  localparam logic [2:0] LB [6] = '{R, R, R, G, Y, R};
  localparam int LEN [6] = '{6, 1, 1, 6, 1, 1};
  // colour index: 0 red, 1 green, 2 yellow
  localparam int DMIN [3] = '{0, 6, 1};
  localparam int DMAX [3] = '{0, 7, 2};

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic [2:0] a = 3'b000, b = 3'b000;
  logic [2:0] phase, fault_code;
  logic phase_valid, fault, err_pulse;
  logic [CW-1:0] cycle_count;

  traffic_light_monitor #(.GREEN_MIN(6), .GREEN_MAX(7), .YEL_MIN(1), .YEL_MAX(2), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .clear(clear),
    .phase(phase), .phase_valid(phase_valid), .cycle_count(cycle_count),
    .fault(fault), .fault_code(fault_code), .err_pulse(err_pulse));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  int m_col [2];
  int m_dw [2];
  int m_last;
  bit m_s1;
  logic [2:0] m_pa, m_pb;
  int e_phase, e_pv, e_cnt, e_fault, e_code, e_pulse;

  function automatic int colour(input logic [2:0] v);
    case (v)
      3'b001:  return 0;
      3'b100:  return 1;
      3'b010:  return 2;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_col = '{-1, -1};
    m_dw = '{0, 0};
    m_last = 0; m_s1 = 0; m_pa = 3'b000; m_pb = 3'b000;
    e_phase = 0; e_pv = 0; e_cnt = 0; e_fault = 0; e_code = 0; e_pulse = 0;
  endtask

  task automatic light_rule(input int i, input int col, output bit inv, output bit seq, output bit tim);
    inv = 0; seq = 0; tim = 0;
    if (col < 0) begin
      inv = 1; m_col[i] = -1; m_dw[i] = 0;
    end else if (m_col[i] < 0) begin
      m_col[i] = col; m_dw[i] = 1;
    end else if (col == m_col[i]) begin
      if (m_dw[i] < CMAX) m_dw[i]++;
      tim = (col != 0) && (m_dw[i] == DMAX[col] + 1);
    end else begin
      // legal order is red -> green -> yellow -> red; too-long dwells were flagged earlier
      seq = (col != (m_col[i] + 1) % 3);
      tim = (m_col[i] != 0) && (m_dw[i] < DMIN[m_col[i]]);
      m_col[i] = col; m_dw[i] = 1;
    end
  endtask

  task automatic model_edge(input logic clr);
    logic [7:0] errs;
    int ac, bc, ph;
    bit ok, wrap, i0, s0, t0, i1, s1, t1;
    errs = '0; wrap = 0;
    if (m_s1) begin
      ac = colour(m_pa); bc = colour(m_pb);
      errs[1] = (ac > 0) && (bc > 0);
      light_rule(0, ac, i0, s0, t0);
      light_rule(1, bc, i1, s1, t1);
      errs[2] = i0; errs[3] = i1; errs[4] = s0; errs[5] = s1; errs[6] = t0; errs[7] = t1;
      ok = 1; ph = e_phase;
      if (ac > 0 && bc == 0) ph = (ac == 2) ? 1 : 0;
      else if (ac == 0 && bc > 0) ph = (bc == 2) ? 4 : 3;
      else if (ac == 0 && bc == 0 && m_last != 0) ph = 3 * m_last - 1;
      else ok = 0;
      if (ok && ph < 2) m_last = 1;
      if (ok && ph > 2 && ph < 5) m_last = 2;
      wrap = ok && ph == 0 && e_pv == 1 && e_phase == 5;
      e_pv = ok; e_phase = ph;
    end
    e_pulse = (errs != 0);
    if (wrap) e_cnt = (e_cnt + 1) % (CMAX + 1);
    if (clr) begin
      e_fault = 0; e_code = 0; e_cnt = 0;
    end else if (errs != 0 && e_fault == 0) begin
      e_fault = 1;
      for (int c = 7; c >= 1; c--) if (errs[c]) e_code = c;
    end
  endtask

  task automatic step(input logic [2:0] na, input logic [2:0] nb, input logic nclr);
    @(negedge clk);
    a = na; b = nb; clear = nclr;
    model_edge(nclr);
    m_pa = na; m_pb = nb; m_s1 = 1;
    @(posedge clk); #1;
  endtask

  task automatic hold(input logic [2:0] na, input logic [2:0] nb, input int n);
    repeat (n) step(na, nb, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({phase, phase_valid, cycle_count, fault, fault_code, err_pulse} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ph=%0d pv=%0b cc=%0d f=%0b fc=%0d ep=%0b want all 0",
               phase, phase_valid, cycle_count, fault, fault_code, err_pulse);
    end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_legal_run();
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < 6; s++) begin
        for (int k = 0; k < LEN[s]; k++) begin
          step(LA[s], LB[s], 1'b0);
          checks++;
          if (phase_valid !== 1'(e_pv) || (e_pv == 1 && phase !== 3'(e_phase))) begin
            errors++;
            $display("FAIL legal_phase got %0d/%0b want %0d/%0d", phase, phase_valid, e_phase, e_pv);
          end
          checks++;
          if (fault !== 1'b0 || cycle_count !== CW'(e_cnt)) begin
            errors++;
            $display("FAIL legal_status got f=%0b cc=%0d want f=0 cc=%0d", fault, cycle_count, e_cnt);
          end
        end
      end
    end
    hold(R, R, 2);
    checks++;
    if (cycle_count !== CW'(2)) begin
      errors++;
      $display("FAIL legal_cycle_count got %0d want 2", cycle_count);
    end
    checks++;
    if (phase !== 3'd5 || phase_valid !== 1'b1 || fault !== 1'b0) begin
      errors++;
      $display("FAIL legal_end got ph=%0d pv=%0b f=%0b want 5/1/0", phase, phase_valid, fault);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    hold(G, R, 3);
    step(G, G, 1'b0);
    checks++;
    if (err_pulse !== 1'b0 || phase !== 3'd0) begin
      errors++;
      $display("FAIL conflict_pre got ep=%0b ph=%0d want 0/0", err_pulse, phase);
    end
    step(G, R, 1'b0);
    checks++;
    if (err_pulse !== 1'b1 || fault !== 1'b1 || fault_code !== 3'd1) begin
      errors++;
      $display("FAIL conflict_hit got ep=%0b f=%0b fc=%0d want 1/1/1", err_pulse, fault, fault_code);
    end
    step(G, R, 1'b0);
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd1) begin
      errors++;
      $display("FAIL conflict_sticky got f=%0b fc=%0d want 1/1", fault, fault_code);
    end
  endtask

  task automatic test_invalid();
    do_reset();
    step(R, R, 1'b0);
    step(3'b011, G, 1'b0);
    step(3'b000, 3'b000, 1'b0);
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd2) begin
      errors++;
      $display("FAIL invalid_priority got f=%0b fc=%0d want 1/2", fault, fault_code);
    end
    step(3'b000, 3'b000, 1'b1);
    checks++;
    if (fault !== 1'b0 || fault_code !== 3'd0 || err_pulse !== 1'b1) begin
      errors++;
      $display("FAIL invalid_clear got f=%0b fc=%0d ep=%0b want 0/0/1", fault, fault_code, err_pulse);
    end
    step(3'b000, R, 1'b0);
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd2) begin
      errors++;
      $display("FAIL invalid_zero got f=%0b fc=%0d want 1/2", fault, fault_code);
    end
    step(G, R, 1'b0);
    step(G, R, 1'b1);
    checks++;
    if (err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL invalid_unk_entry got ep=%0b want 0", err_pulse);
    end
    step(G, R, 1'b0);
    checks++;
    if (fault !== 1'b0 || err_pulse !== 1'b0 || phase !== 3'd0) begin
      errors++;
      $display("FAIL invalid_recover got f=%0b ep=%0b ph=%0d want 0/0/0", fault, err_pulse, phase);
    end
  endtask

  task automatic test_sequence();
    do_reset();
    hold(G, R, 6);
    hold(R, R, 2);
    checks++;
    if (err_pulse !== 1'b1 || fault_code !== 3'd4) begin
      errors++;
      $display("FAIL seq_a got ep=%0b fc=%0d want 1/4", err_pulse, fault_code);
    end
    do_reset();
    hold(R, R, 2);
    hold(R, Y, 2);
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd5) begin
      errors++;
      $display("FAIL seq_b got f=%0b fc=%0d want 1/5", fault, fault_code);
    end
  endtask

  task automatic test_timing();
    do_reset();
    hold(G, R, 8);
    checks++;
    if (err_pulse !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL tim_wd_early got ep=%0b f=%0b want 0/0", err_pulse, fault);
    end
    step(Y, R, 1'b0);
    checks++;
    if (err_pulse !== 1'b1 || fault_code !== 3'd6) begin
      errors++;
      $display("FAIL tim_wd_fire got ep=%0b fc=%0d want 1/6", err_pulse, fault_code);
    end
    step(Y, R, 1'b0);
    checks++;
    if (err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL tim_wd_exit got ep=%0b want 0", err_pulse);
    end
    do_reset();
    hold(G, R, 5);
    hold(Y, R, 2);
    checks++;
    if (err_pulse !== 1'b1 || fault_code !== 3'd6) begin
      errors++;
      $display("FAIL tim_short_green got ep=%0b fc=%0d want 1/6", err_pulse, fault_code);
    end
    do_reset();
    hold(R, G, 6);
    hold(R, Y, 3);
    checks++;
    if (err_pulse !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL tim_yel_ok got ep=%0b f=%0b want 0/0", err_pulse, fault);
    end
    step(R, R, 1'b0);
    checks++;
    if (err_pulse !== 1'b1 || fault_code !== 3'd7) begin
      errors++;
      $display("FAIL tim_long_yel got ep=%0b fc=%0d want 1/7", err_pulse, fault_code);
    end
  endtask

  task automatic test_clear_reset();
    do_reset();
    hold(G, R, 3);
    step(G, G, 1'b0);
    step(G, R, 1'b1);
    checks++;
    if (fault !== 1'b0 || fault_code !== 3'd0 || err_pulse !== 1'b1) begin
      errors++;
      $display("FAIL clear_vs_conflict got f=%0b fc=%0d ep=%0b want 0/0/1", fault, fault_code, err_pulse);
    end
    do_reset();
    hold(R, G, 3);
    checks++;
    if (phase !== 3'd3 || phase_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_phase3 got ph=%0d pv=%0b want 3/1", phase, phase_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({phase, phase_valid, cycle_count, fault, fault_code, err_pulse} !== '0) begin
      errors++;
      $display("FAIL mid_reset got ph=%0d pv=%0b cc=%0d f=%0b fc=%0d ep=%0b want all 0",
               phase, phase_valid, cycle_count, fault, fault_code, err_pulse);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    hold(R, Y, 2);
    checks++;
    if (fault !== 1'b0 || err_pulse !== 1'b0 || phase !== 3'd4) begin
      errors++;
      $display("FAIL post_reset got f=%0b ep=%0b ph=%0d want 0/0/4", fault, err_pulse, phase);
    end
  endtask

  task automatic test_random();
    int ph, len;
    logic [2:0] na, nb;
    logic nclr;
    do_reset();
    for (int s = 0; s < 48; s++) begin
      ph = s % 6;
      case (ph)
        0, 3:    len = $urandom_range(4, 9);
        1, 4:    len = $urandom_range(1, 3);
        default: len = $urandom_range(1, 2);
      endcase
      for (int k = 0; k < len; k++) begin
        na = LA[ph]; nb = LB[ph];
        if ($urandom_range(0, 11) == 0) na = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 11) == 0) nb = 3'($urandom_range(0, 7));
        nclr = ($urandom_range(0, 19) == 0);
        step(na, nb, nclr);
        checks++;
        if (phase !== 3'(e_phase) || phase_valid !== 1'(e_pv)) begin
          errors++;
          $display("FAIL rnd_phase got %0d/%0b want %0d/%0d", phase, phase_valid, e_phase, e_pv);
        end
        checks++;
        if (cycle_count !== CW'(e_cnt)) begin
          errors++;
          $display("FAIL rnd_cycle got %0d want %0d", cycle_count, e_cnt);
        end
        checks++;
        if (fault !== 1'(e_fault) || fault_code !== 3'(e_code)) begin
          errors++;
          $display("FAIL rnd_fault got %0b/%0d want %0d/%0d", fault, fault_code, e_fault, e_code);
        end
        checks++;
        if (err_pulse !== 1'(e_pulse)) begin
          errors++;
          $display("FAIL rnd_pulse got %0b want %0d", err_pulse, e_pulse);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    test_reset();
    test_legal_run();
    test_conflict();
    test_invalid();
    test_sequence();
    test_timing();
    test_clear_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
